// File: rtl/tdm_acc_pkg.sv
// Shared types and helpers for the TDM frame accumulator.
package tdm_acc_pkg;

  typedef enum logic {ST_SYNC, ST_ACC} state_e;

  // Width of a channel index; a single-channel build still carries one bit.
  function automatic int unsigned chn_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a signed value that fits in in_w bits into the out_w signed range.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int unsigned       in_w,
                                                   input int unsigned       out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (out_w >= in_w) return value;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/tdm_acc_narrow.sv
// Shift-and-narrow stage: arithmetic right shift of the exact frame sum,
// then fit into the output width. Define TDM_ACC_SAT_EN to clamp
// out-of-range results; otherwise the low bits are kept (wrap).
module tdm_acc_narrow
  import tdm_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] dat_o
);

  logic signed [ACC_W-1:0] shifted;

  // Shift, then saturate or wrap into OUT_W.
  always_comb begin
    shifted = acc_i >>> SHIFT;
`ifdef TDM_ACC_SAT_EN
    dat_o = OUT_W'(sat_trunc(64'(shifted), ACC_W - SHIFT, OUT_W));
`else
    dat_o = OUT_W'(shifted);
`endif
  end

endmodule

// File: rtl/tdm_frame_accumulator.sv
// Accumulates NUM_CHANNELS consecutive TDM samples into one output sample,
// with channel-sequence checking, resync and a frame index.
// Optional build macro: TDM_ACC_SAT_EN (saturating output narrowing).
module tdm_frame_accumulator
  import tdm_acc_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned SHIFT        = 0,
  parameter int unsigned FRM_W        = 8
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_vld,
  output logic                                   o_rdy,
  input  logic signed [DATA_W-1:0]               i_stm_dat,
  input  logic [chn_width(NUM_CHANNELS)-1:0]     i_stm_chn,
  input  logic                                   i_tlast,
  output logic                                   o_vld,
  input  logic                                   i_rdy,
  output logic signed [OUT_W-1:0]                o_stm_dat,
  output logic                                   o_tlast,
  output logic [FRM_W-1:0]                       o_frm_idx,
  output logic                                   o_err
);

  localparam int unsigned CHN_W = chn_width(NUM_CHANNELS);
  localparam int unsigned ACC_W = DATA_W + CHN_W;
  localparam logic [CHN_W-1:0] LAST_CHN = CHN_W'(NUM_CHANNELS - 1);

  state_e                  state_q;
  logic [CHN_W-1:0]        exp_chn_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    tlast_acc_q;
  logic [FRM_W-1:0]        frm_cnt_q;
  logic                    o_vld_q;
  logic signed [OUT_W-1:0] o_dat_q;
  logic                    o_tlast_q;
  logic [FRM_W-1:0]        o_frm_idx_q;
  logic                    o_err_q;

  logic                    accept;
  logic                    in_order;
  logic                    seq_err;
  logic signed [ACC_W-1:0] acc_d;
  logic                    tlast_acc_d;
  logic signed [OUT_W-1:0] result;

  assign o_rdy     = !o_vld_q || i_rdy;
  assign o_vld     = o_vld_q;
  assign o_stm_dat = o_dat_q;
  assign o_tlast   = o_tlast_q;
  assign o_frm_idx = o_frm_idx_q;
  assign o_err     = o_err_q;

  // Classify the current beat and form the running sum; channel 0 always
  // restarts the frame, so it also serves as the recovery path after an error.
  always_comb begin
    accept      = i_vld && o_rdy;
    in_order    = (i_stm_chn == '0) || (state_q == ST_ACC && i_stm_chn == exp_chn_q);
    seq_err     = (state_q == ST_ACC) && (i_stm_chn != exp_chn_q);
    acc_d       = ((i_stm_chn == '0) ? '0 : acc_q) + ACC_W'(i_stm_dat);
    tlast_acc_d = ((i_stm_chn == '0) ? 1'b0 : tlast_acc_q) | i_tlast;
  end

  tdm_acc_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_narrow (
    .acc_i (acc_d),
    .dat_o (result)
  );

  // Sequence FSM, accumulator and registered output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_SYNC;
      exp_chn_q   <= '0;
      acc_q       <= '0;
      tlast_acc_q <= 1'b0;
      frm_cnt_q   <= '0;
      o_vld_q     <= 1'b0;
      o_dat_q     <= '0;
      o_tlast_q   <= 1'b0;
      o_frm_idx_q <= '0;
      o_err_q     <= 1'b0;
    end else begin
      o_err_q <= 1'b0;
      if (o_vld_q && i_rdy) o_vld_q <= 1'b0;
      if (accept) begin
        if (seq_err) o_err_q <= 1'b1;
        if (in_order) begin
          state_q <= ST_ACC;
          if (i_stm_chn == LAST_CHN) begin
            o_vld_q     <= 1'b1;
            o_dat_q     <= result;
            o_tlast_q   <= tlast_acc_d;
            o_frm_idx_q <= frm_cnt_q;
            frm_cnt_q   <= frm_cnt_q + FRM_W'(1);
            exp_chn_q   <= '0;
            acc_q       <= '0;
            tlast_acc_q <= 1'b0;
          end else begin
            acc_q       <= acc_d;
            tlast_acc_q <= tlast_acc_d;
            exp_chn_q   <= i_stm_chn + CHN_W'(1);
          end
        end else if (seq_err) begin
          state_q     <= ST_SYNC;
          exp_chn_q   <= '0;
          acc_q       <= '0;
          tlast_acc_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_frame_accumulator.sv
// Scoreboard bench for tdm_frame_accumulator with a frame-level reference model.
module tb_tdm_frame_accumulator;

  localparam int N  = 4;
  localparam int DW = 14;
  localparam int OW = 12;
  localparam int SH = 1;
  localparam int FW = 8;

  logic                 clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_vld;
  logic                 o_rdy;
  logic signed [DW-1:0] i_stm_dat;
  logic [1:0]           i_stm_chn;
  logic                 i_tlast;
  logic                 o_vld;
  logic                 i_rdy;
  logic signed [OW-1:0] o_stm_dat;
  logic                 o_tlast;
  logic [FW-1:0]        o_frm_idx;
  logic                 o_err;

  always #5 clk = ~clk;

  tdm_frame_accumulator #(
    .NUM_CHANNELS (N),
    .DATA_W       (DW),
    .OUT_W        (OW),
    .SHIFT        (SH),
    .FRM_W        (FW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_stm_dat (i_stm_dat),
    .i_stm_chn (i_stm_chn),
    .i_tlast   (i_tlast),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_stm_dat (o_stm_dat),
    .o_tlast   (o_tlast),
    .o_frm_idx (o_frm_idx),
    .o_err     (o_err)
  );

  typedef struct {
    int dat;
    bit tl;
    int idx;
  } out_t;

  out_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_pct = 100;

  // Reference model state: the beats of the frame collected so far.
  int   frame[$];
  bit   tl_any;
  bit   synced;
  int   frm_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_result(input int sum);
    int r;
    r = sum >>> SH;
`ifdef TDM_ACC_SAT_EN
    if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
    if (r < -(1 << (OW - 1))) r = -(1 << (OW - 1));
`else
    r = r & ((1 << OW) - 1);
    if (r >= (1 << (OW - 1))) r = r - (1 << OW);
`endif
    return r;
  endfunction

  task automatic model_reset();
    frame.delete();
    exp_q.delete();
    err_q.delete();
    tl_any  = 1'b0;
    synced  = 1'b0;
    frm_cnt = 0;
  endtask

  task automatic model_accept(input int c, input int d, input bit t);
    int   sum;
    out_t o;
    if (!synced) begin
      if (c == 0) begin
        frame.delete();
        frame.push_back(d);
        tl_any = t;
        synced = 1'b1;
      end
    end else if (c == frame.size()) begin
      frame.push_back(d);
      tl_any = (frame.size() == 1) ? t : (tl_any | t);
    end else begin
      err_q.push_back(cyc + 1);
      frame.delete();
      if (c == 0) begin
        frame.push_back(d);
        tl_any = t;
      end else begin
        synced = 1'b0;
      end
    end
    if (synced && frame.size() == N) begin
      sum = 0;
      foreach (frame[k]) sum += frame[k];
      o.dat = model_result(sum);
      o.tl  = tl_any;
      o.idx = frm_cnt;
      exp_q.push_back(o);
      frm_cnt = (frm_cnt + 1) % (1 << FW);
      frame.delete();
    end
  endtask

  // Monitor: error pulses, hold stability while stalled, and output handshakes.
  bit                   held = 1'b0;
  logic signed [OW-1:0] h_dat;
  logic                 h_tl;
  logic [FW-1:0]        h_idx;

  always @(negedge clk) begin
    if (!i_rst_n) begin
      held = 1'b0;
    end else begin
      if (o_err) begin
        checks++;
        if (err_q.size() == 0 || err_q[0] != cyc) begin
          errors++;
          $display("FAIL err_pulse: got pulse at cycle %0d, expected %0s", cyc,
                   (err_q.size() == 0) ? "none" : "other cycle");
        end
        if (err_q.size() > 0 && err_q[0] <= cyc) void'(err_q.pop_front());
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL err_pulse: got 0 at cycle %0d, expected 1", cyc);
        void'(err_q.pop_front());
      end
      if (held) begin
        checks++;
        if (o_vld !== 1'b1 || o_stm_dat !== h_dat || o_tlast !== h_tl || o_frm_idx !== h_idx) begin
          errors++;
          $display("FAIL hold: got vld=%0b dat=%0d tl=%0b idx=%0d, expected vld=1 dat=%0d tl=%0b idx=%0d",
                   o_vld, o_stm_dat, o_tlast, o_frm_idx, h_dat, h_tl, h_idx);
        end
      end
      if (o_vld && i_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL output: got dat=%0d idx=%0d, expected no output", o_stm_dat, o_frm_idx);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          if (int'(o_stm_dat) != e.dat || o_tlast != e.tl || int'(o_frm_idx) != e.idx) begin
            errors++;
            $display("FAIL output: got dat=%0d tl=%0b idx=%0d, expected dat=%0d tl=%0b idx=%0d",
                     o_stm_dat, o_tlast, o_frm_idx, e.dat, e.tl, e.idx);
          end
        end
      end
      held  = o_vld && !i_rdy;
      h_dat = o_stm_dat;
      h_tl  = o_tlast;
      h_idx = o_frm_idx;
    end
  end

  // Downstream ready generator.
  initial begin
    i_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic idle(input int n);
    i_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int c, input int d, input bit t);
    int waited;
    i_vld     = 1'b1;
    i_stm_chn = 2'(c);
    i_stm_dat = DW'(d);
    i_tlast   = t;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (o_rdy) begin
        model_accept(c, d, t);
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got o_rdy=0 for %0d cycles, expected acceptance", waited);
        i_vld = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_vld   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_bit("rst_o_vld", o_vld, 1'b0);
    check_bit("rst_o_tlast", o_tlast, 1'b0);
    check_bit("rst_o_err", o_err, 1'b0);
    checks++;
    if (o_stm_dat !== '0 || o_frm_idx !== '0) begin
      errors++;
      $display("FAIL rst_data: got dat=%0d idx=%0d, expected 0 0", o_stm_dat, o_frm_idx);
    end
    i_rst_n = 1'b1;
    check_bit("rdy_after_reset", o_rdy, 1'b1);
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    i_vld = 1'b0;
    while ((o_vld || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs, expected 0", exp_q.size());
    end
  endtask

  int nchn;

  initial begin
    i_rst_n   = 1'b0;
    i_vld     = 1'b0;
    i_stm_dat = '0;
    i_stm_chn = '0;
    i_tlast   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic frame.
    send(0, 100, 0); send(1, -20, 0); send(2, 5, 0); send(3, 7, 0);
    // Three back-to-back frames, tlast only in the middle one.
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < N; c++) send(c, 1000 * (f + 1) - 37 * c, (f == 1 && c == 2));
    // Sequence error, then resync drop, then a clean frame.
    send(0, 3, 0); send(1, 3, 0); send(3, 3, 0);
    send(2, 9, 0); send(1, 9, 0);
    send(0, 1, 0); send(1, 1, 0); send(2, 1, 0); send(3, 1, 0);
    // Error on a channel-0 beat restarts immediately.
    send(0, 50, 0); send(1, 50, 0); send(0, 2, 1); send(1, 2, 0); send(2, 2, 0); send(3, 2, 0);
    // Extremes.
    for (int c = 0; c < N; c++) send(c, 8191, 0);
    for (int c = 0; c < N; c++) send(c, -8192, 0);
    for (int c = 0; c < N; c++) send(c, (c == 3) ? -3 : 0, 0);

    // Stalled output: o_rdy low and result held while downstream is not ready.
    wait_drained();
    rdy_pct = 0;
    idle(2);
    send(0, 10, 0); send(1, 10, 0); send(2, 10, 0); send(3, 11, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_bit("stall_o_rdy", o_rdy, 1'b0);
      @(posedge clk);
      #1;
    end
    rdy_pct = 100;
    send(0, -7, 1); send(1, 4, 0); send(2, 4, 0); send(3, 4, 0);

    // Randomised traffic with backpressure and occasional sequence faults.
    rdy_pct = 60;
    nchn = 0;
    for (int b = 0; b < 400; b++) begin
      int c;
      int d;
      if ($urandom_range(0, 99) < 88) c = nchn;
      else c = $urandom_range(0, N - 1);
      nchn = (c + 1) % N;
      d = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 8191 : -8192)
                                      : (int'($urandom_range(0, 16383)) - 8192);
      send(c, d, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_pct = 100;
    wait_drained();

    // Reset mid-frame: partial sum discarded, frame index restarts.
    send(0, 500, 1); send(1, 500, 0);
    do_reset();
    send(1, 77, 0); send(2, 77, 0);
    send(0, 5, 0); send(1, 6, 0); send(2, 7, 0); send(3, 8, 0);

    wait_drained();
    idle(4);
    checks++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d outputs and %0d error pulses outstanding, expected 0 0",
               exp_q.size(), err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
